// File: rtl/imem_loader_if.sv
// Bundle between the UART receiver / debug controller side and the instruction-memory write port.
interface imem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_instruction;
    logic [31:0] wr_addr;
    logic [31:0] data_instruction;
    logic        busy;
    logic        load_done;
    logic        full;
    logic [5:0]  word_count;

    modport master (
        output start, rx_data, rx_valid,
        input  wr_instruction, wr_addr, data_instruction, busy, load_done, full, word_count
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output wr_instruction, wr_addr, data_instruction, busy, load_done, full, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles UART bytes (MSB first) into 32-bit instructions and writes them to instruction memory
// until a halt word is seen or the memory is full.
module imem_loader #(
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   shreg_reg, shreg_next;
    logic [1:0]    byte_idx_reg, byte_idx_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [31:0]   data_reg, data_next;
    logic          wr_reg, wr_next;
    logic [5:0]    word_count_reg, word_count_next;
    logic          full_reg, full_next;
    logic          done_reg, done_next;
    logic          busy_reg, busy_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            byte_idx_reg   <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            wr_reg         <= 1'b0;
            word_count_reg <= '0;
            full_reg       <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            byte_idx_reg   <= byte_idx_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            wr_reg         <= wr_next;
            word_count_reg <= word_count_next;
            full_reg       <= full_next;
            done_reg       <= done_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        byte_idx_next   = byte_idx_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        wr_next         = 1'b0;
        word_count_next = word_count_reg;
        full_next       = full_reg;
        done_next       = done_reg;

        case (state_reg)
            IDLE, DONE: begin
                // A byte arriving together with start is deliberately dropped.
                if (bus.start) begin
                    byte_idx_next   = '0;
                    addr_next       = '0;
                    word_count_next = '0;
                    full_next       = 1'b0;
                    done_next       = 1'b0;
                    state_next      = RECV;
                end
            end

            RECV: begin
                if (bus.rx_valid) begin
                    shreg_next = {shreg_reg[23:0], bus.rx_data};
                    if (byte_idx_reg == 2'd3) begin
                        data_next     = {shreg_reg[23:0], bus.rx_data};
                        byte_idx_next = '0;
                        wr_next       = 1'b1;
                        state_next    = WRITE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end
                end
            end

            WRITE: begin
                word_count_next = word_count_reg + 6'd1;
                // shreg still holds the completed word during this cycle.
                if (shreg_reg == HALT_WORD) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else if (addr_reg == LAST_ADDR) begin
                    full_next  = 1'b1;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    addr_next  = addr_reg + AW'(1);
                    state_next = RECV;
                end
                // A byte landing in the write cycle becomes byte 0 of the next word.
                if (bus.rx_valid) begin
                    shreg_next    = {shreg_reg[23:0], bus.rx_data};
                    byte_idx_next = 2'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == RECV) || (state_next == WRITE);
    end

    assign bus.wr_instruction   = wr_reg;
    assign bus.wr_addr          = 32'(addr_reg);
    assign bus.data_instruction = data_reg;
    assign bus.busy             = busy_reg;
    assign bus.load_done        = done_reg;
    assign bus.full             = full_reg;
    assign bus.word_count       = word_count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: a byte-level load model predicts every memory write.
module tb_imem_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if bus();

    imem_loader #(.MEM_DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    // Reference model of one load: bytes collected while active, four make a word.
    bit         m_active;
    bit         m_done;
    bit         m_full;
    int         m_count;
    logic [7:0] m_bytes[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_full   = 1'b0;
        m_count  = 0;
        m_bytes.delete();
    endfunction

    function automatic void model_step(input bit s, input bit v, input logic [7:0] d);
        wr_t w;
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_full   = 1'b0;
                m_count  = 0;
                m_bytes.delete();
            end
        end else if (v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                w.addr = m_count;
                w.data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                exp_q.push_back(w);
                m_count++;
                if (w.data == HALT) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else if (m_count == DEPTH) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_full   = 1'b1;
                end
            end
        end
    endfunction

    // One clock: inputs held across the edge, model advanced just after it.
    task automatic cycle(input bit s, input bit v, input logic [7:0] d);
        bus.start    = s;
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
        model_step(s, v, d);
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, input bit strays);
        for (int i = 0; i < 4; i++) begin
            cycle(strays && ($urandom_range(0, 7) == 0), 1'b1, w[31-8*i -: 8]);
            idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic check_status(input string tag);
        idle(3);
        chk({tag, ".busy"},       32'(bus.busy),       32'(m_active));
        chk({tag, ".load_done"},  32'(bus.load_done),  32'(m_done));
        chk({tag, ".full"},       32'(bus.full),       32'(m_full));
        chk({tag, ".word_count"}, 32'(bus.word_count), 32'(m_count));
    endtask

    // Asserts reset in the middle of a cycle and checks that outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, ".wr_instruction"},   32'(bus.wr_instruction), 32'd0);
        chk({tag, ".wr_addr"},          bus.wr_addr,             32'd0);
        chk({tag, ".data_instruction"}, bus.data_instruction,    32'd0);
        chk({tag, ".busy"},             32'(bus.busy),           32'd0);
        chk({tag, ".load_done"},        32'(bus.load_done),      32'd0);
        chk({tag, ".full"},             32'(bus.full),           32'd0);
        chk({tag, ".word_count"},       32'(bus.word_count),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write pulse must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst && bus.wr_instruction) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%h expected no write",
                         bus.wr_addr, bus.data_instruction);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=%h", bus.wr_addr, bus.data_instruction);
                chk("write.addr", bus.wr_addr, e.addr);
                chk("write.data", bus.data_instruction, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    logic [7:0]  bb[12];
    logic [31:0] word;
    int          n;

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();

        // Power-on reset, then bytes without start must not write.
        #2 rst = 1'b0;
        #1;
        chk("por.busy",       32'(bus.busy),       32'd0);
        chk("por.word_count", 32'(bus.word_count), 32'd0);
        chk("por.wr",         32'(bus.wr_instruction), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h1234_5678, 0, 1'b0);
        check_status("nostart");

        // Basic load: one instruction followed by halt.
        cycle(1'b1, 1'b0, 8'h00);
        send_word(32'h0022_1820, 1, 1'b0);
        send_word(HALT, 1, 1'b0);
        check_status("basic");
        chk("basic.count_const", 32'(bus.word_count), 32'd2);

        // Reset while outputs are non-zero.
        async_reset("rst_done");

        // Fill the whole memory without a halt word.
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= DEPTH; i++) send_word(32'(i), 0, 1'b0);
        check_status("full");
        chk("full.flag_const", 32'(bus.full), 32'd1);
        send_word(32'h0102_0304, 0, 1'b0);
        check_status("full_after");

        // Bytes on every cycle, including the write cycles.
        bb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
        idle(2);
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, bb[i]);
        check_status("b2b");

        // start while busy is ignored, reset mid-word discards it.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'hA1);
        cycle(1'b0, 1'b1, 8'hA2);
        cycle(1'b1, 1'b0, 8'h00);
        chk("midstart.busy", 32'(bus.busy), 32'd1);
        cycle(1'b0, 1'b1, 8'hA3);
        cycle(1'b0, 1'b1, 8'hA4);
        cycle(1'b0, 1'b1, 8'hB1);
        cycle(1'b0, 1'b1, 8'hB2);
        async_reset("rst_mid");
        idle(2);
        chk("rst_mid.no_write", 32'(exp_q.size()), 32'd0);
        cycle(1'b1, 1'b0, 8'h00);
        send_word(32'hDEAD_BEEF, 1, 1'b0);
        send_word(HALT, 1, 1'b0);
        check_status("after_rst");

        // Reload from DONE.
        cycle(1'b1, 1'b0, 8'h00);
        chk("reload.load_done", 32'(bus.load_done), 32'd0);
        chk("reload.busy",      32'(bus.busy),      32'd1);
        send_word(32'h0BAD_F00D, 0, 1'b0);
        send_word(HALT, 0, 1'b0);
        check_status("reload");
        chk("reload.count_const", 32'(bus.word_count), 32'd2);

        // Randomised loads with gaps, stray starts and occasional early halts.
        for (int l = 0; l < 8; l++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            n = $urandom_range(1, 40);
            for (int w = 0; w < n && m_active; w++) begin
                word = $urandom;
                if (word == HALT) word = 32'h0;
                if (w == n - 1 || $urandom_range(0, 9) == 0) word = HALT;
                send_word(word, 2, 1'b1);
            end
            check_status($sformatf("rand%0d", l));
        end

        idle(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
